// File: rtl/dmem_ctrl.sv
// Single-port data memory with a hardware zero-init sequencer, registered read-before-write responses
// and a combinational monitor port. Define DMEM_PRESET_EN to load preset words after the clear pass.
module dmem_ctrl #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned DEPTH      = 64,
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned MON_ADDR_W = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_be,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    output logic                  init_done,
    input  logic [MON_ADDR_W-1:0] monitor_addr,
    output logic [DATA_W-1:0]     monitor_data
);

    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned CNT_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DEPTH - 1);

`ifdef DMEM_PRESET_EN
    typedef enum logic [1:0] {ST_CLEAR, ST_PRESET, ST_READY} state_e;
`else
    typedef enum logic [1:0] {ST_CLEAR, ST_READY} state_e;
`endif

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    clear_cnt_q, clear_cnt_d;
    logic                ready_q, ready_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic                in_range_c;
    logic                wr_en_c;
    logic [CNT_W-1:0]    acc_idx_c;
    logic                mon_in_range_c;
    logic [CNT_W-1:0]    mon_idx_c;

    assign in_range_c     = (32'(req_addr) < DEPTH);
    assign acc_idx_c      = CNT_W'(req_addr);
    assign wr_en_c        = (state_q == ST_READY) && req_valid && req_we && in_range_c;
    assign mon_in_range_c = (32'(monitor_addr) < DEPTH);
    assign mon_idx_c      = CNT_W'(monitor_addr);

    // State, clear counter and response registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_CLEAR;
            clear_cnt_q <= '0;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            clear_cnt_q <= clear_cnt_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // Next-state and response computation; the read samples the word before any same-edge write
    always_comb begin
        state_d     = state_q;
        clear_cnt_d = clear_cnt_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        case (state_q)
            ST_CLEAR: begin
                clear_cnt_d = clear_cnt_q + CNT_W'(1);
                if (clear_cnt_q == LAST_IDX) begin
`ifdef DMEM_PRESET_EN
                    state_d = ST_PRESET;
`else
                    state_d = ST_READY;
`endif
                end
            end
`ifdef DMEM_PRESET_EN
            ST_PRESET: state_d = ST_READY;
`endif
            ST_READY: begin
                if (req_valid) begin
                    rsp_valid_d = 1'b1;
                    if (in_range_c) begin
                        rsp_rdata_d = mem_q[acc_idx_c];
                    end else begin
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                    end
                end
            end
            default: state_d = ST_CLEAR;
        endcase
        ready_d = (state_d == ST_READY);
    end

    // Storage array is never reset; the clear pass provides the known contents
    always_ff @(posedge clk) begin
        if (state_q == ST_CLEAR) begin
            mem_q[clear_cnt_q] <= '0;
        end
`ifdef DMEM_PRESET_EN
        else if (state_q == ST_PRESET) begin
            mem_q[0] <= DATA_W'(1);
            mem_q[1] <= DATA_W'(2);
            mem_q[5] <= DATA_W'(4);
        end
`endif
        else if (wr_en_c) begin
            for (int i = 0; i < int'(BE_W); i++) begin
                if (req_be[i]) begin
                    mem_q[acc_idx_c][8*i +: 8] <= req_wdata[8*i +: 8];
                end
            end
        end
    end

    assign req_ready    = ready_q;
    assign init_done    = ready_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_err      = rsp_err_q;
    assign rsp_rdata    = rsp_rdata_q;
    assign monitor_data = mon_in_range_c ? mem_q[mon_idx_c] : '0;

endmodule
